// File: rtl/noc_input_port_buffer_if.sv
// noc_input_port_buffer_if
//   Flit/valid/credit link plus head-of-queue presentation signals for the
//   NoC input port buffer.
//   slave  : buffer side (receives in/vi/grant/IDs, drives head_* / co / count)
//   master : sender plus router side (drives in/vi/grant/IDs, observes outputs)
//   Optional macro NOC_IPB_OVERFLOW_CHK_EN adds the ovf_err signal.
interface noc_input_port_buffer_if #(
    parameter int CNT_W = 3
);
    logic [19:0]      in;          // [19:18] dest cluster, [17:16] dest local, [15:0] payload
    logic             vi;          // flit valid
    logic [1:0]       my_cluster;  // this node's cluster ID
    logic [1:0]       my_local;    // this node's local ID
    logic             grant;       // head flit consumed this cycle
    logic [19:0]      head_flit;   // flit at FIFO head
    logic             head_valid;  // FIFO non-empty
    logic             head_local;  // head destined for this node
    logic             co;          // credit return pulse
    logic [CNT_W-1:0] count;       // occupancy
`ifdef NOC_IPB_OVERFLOW_CHK_EN
    logic             ovf_err;     // sticky overflow flag
`endif

    modport slave (
        input  in, vi, my_cluster, my_local, grant,
        output head_flit, head_valid, head_local, co, count
`ifdef NOC_IPB_OVERFLOW_CHK_EN
        , output ovf_err
`endif
    );

    modport master (
        output in, vi, my_cluster, my_local, grant,
        input  head_flit, head_valid, head_local, co, count
`ifdef NOC_IPB_OVERFLOW_CHK_EN
        , input ovf_err
`endif
    );
endinterface

// File: rtl/noc_input_port_buffer.sv
// noc_input_port_buffer
//   Receiving end of a credit-based flit link. Flits are stored in a circular
//   FIFO of DEPTH slots; the head flit is presented combinationally from
//   storage along with a local-destination decode. Every dequeued flit
//   returns one registered credit pulse upstream.
// Ports:
//   clk  - system clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - noc_input_port_buffer_if.slave (in, vi, my_cluster, my_local,
//          grant -> head_flit, head_valid, head_local, co, count)
// Optional feature: define NOC_IPB_OVERFLOW_CHK_EN to add the sticky
//   bus.ovf_err flag (plus a simulation $error naming the dropped flit).
module noc_input_port_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    noc_input_port_buffer_if.slave        bus
);
    localparam int               PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [19:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_co;

    logic             w_head_valid;
    logic             w_wr;
    logic             w_rd;
    logic [19:0]      w_head_flit;

    // Full/empty come from the occupancy count, never from pointer compare.
    // A flit arriving while full is dropped even if a read frees a slot on
    // the same edge.
    assign w_head_valid = (r_count != '0);
    assign w_wr         = bus.vi && (r_count != FULL);
    assign w_rd         = bus.grant && w_head_valid;
    assign w_head_flit  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_co     <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
            r_co    <= w_rd;
        end
    end

    // Storage carries no reset; contents are only observed while valid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= bus.in;
    end

    assign bus.head_flit  = w_head_flit;
    assign bus.head_valid = w_head_valid;
    assign bus.head_local = w_head_valid &&
                            (w_head_flit[19:18] == bus.my_cluster) &&
                            (w_head_flit[17:16] == bus.my_local);
    assign bus.co         = r_co;
    assign bus.count      = r_count;

`ifdef NOC_IPB_OVERFLOW_CHK_EN
    logic r_ovf_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (bus.vi && (r_count == FULL)) begin
            r_ovf_err <= 1'b1;
`ifndef SYNTHESIS
            $error("noc_input_port_buffer: overflow, dropped flit 0x%05h", bus.in);
`endif
        end
    end

    assign bus.ovf_err = r_ovf_err;
`endif

endmodule

// File: tb/tb_noc_input_port_buffer.sv
module tb_noc_input_port_buffer;
    logic clk;
    logic rst;

    noc_input_port_buffer_if #(.CNT_W(3)) ifc ();

    noc_input_port_buffer #(
        .DEPTH (4),
        .CNT_W (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vi;
        logic [19:0] in;
        logic        grant;
        logic [1:0]  mc;
        logic [1:0]  ml;
        logic        hv;
        logic [19:0] hf;
        logic        hl;
        logic        co;
        logic [2:0]  cnt;
        logic        ovf;
    } vec_t;

    int unsigned errors = 0;
    int unsigned checks = 0;
    vec_t vecs[$];

    function automatic vec_t v(logic r, logic vi, logic [19:0] in, logic g,
                               logic [1:0] mc, logic [1:0] ml, logic hv,
                               logic [19:0] hf, logic hl, logic co,
                               logic [2:0] cnt, logic ovf);
        vec_t t;
        t.rst = r; t.vi = vi; t.in = in; t.grant = g; t.mc = mc; t.ml = ml;
        t.hv = hv; t.hf = hf; t.hl = hl; t.co = co; t.cnt = cnt; t.ovf = ovf;
        return t;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [step %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst            = t.rst;
        ifc.vi         = t.vi;
        ifc.in         = t.in;
        ifc.grant      = t.grant;
        ifc.my_cluster = t.mc;
        ifc.my_local   = t.ml;
    endtask

    task automatic check_outs(input vec_t t, input int idx);
        chk("head_valid", idx, 32'(ifc.head_valid), 32'(t.hv));
        chk("head_local", idx, 32'(ifc.head_local), 32'(t.hl));
        chk("co",         idx, 32'(ifc.co),         32'(t.co));
        chk("count",      idx, 32'(ifc.count),      32'(t.cnt));
        if (t.hv) chk("head_flit", idx, 32'(ifc.head_flit), 32'(t.hf));
`ifdef NOC_IPB_OVERFLOW_CHK_EN
        chk("ovf_err",    idx, 32'(ifc.ovf_err),    32'(t.ovf));
`endif
    endtask

    initial begin
        //          rst vi  in        g   mc ml   hv  hf        hl  co  cnt ovf
        vecs.push_back(v(1, 0, 20'h0,     0, 2, 1, 0, 20'h0,     0, 0, 0, 0)); // 0 reset
        vecs.push_back(v(0, 1, 20'h9ABCD, 0, 2, 1, 1, 20'h9ABCD, 1, 0, 1, 0)); // 1 first write, local
        vecs.push_back(v(0, 0, 20'h0,     1, 2, 1, 0, 20'h0,     0, 1, 0, 0)); // 2 dequeue
        vecs.push_back(v(0, 0, 20'h0,     0, 2, 1, 0, 20'h0,     0, 0, 0, 0)); // 3 idle
        vecs.push_back(v(0, 1, 20'h00001, 0, 2, 1, 1, 20'h00001, 0, 0, 1, 0)); // 4 fill
        vecs.push_back(v(0, 1, 20'h00002, 0, 2, 1, 1, 20'h00001, 0, 0, 2, 0));
        vecs.push_back(v(0, 1, 20'h00003, 0, 2, 1, 1, 20'h00001, 0, 0, 3, 0));
        vecs.push_back(v(0, 1, 20'h00004, 0, 2, 1, 1, 20'h00001, 0, 0, 4, 0)); // 7 full
        vecs.push_back(v(0, 1, 20'h00005, 0, 2, 1, 1, 20'h00001, 0, 0, 4, 1)); // 8 dropped
        vecs.push_back(v(0, 1, 20'h00006, 1, 2, 1, 1, 20'h00002, 0, 1, 3, 1)); // 9 no write-through at full
        vecs.push_back(v(0, 0, 20'h0,     1, 2, 1, 1, 20'h00003, 0, 1, 2, 1));
        vecs.push_back(v(0, 0, 20'h0,     1, 2, 1, 1, 20'h00004, 0, 1, 1, 1));
        vecs.push_back(v(0, 0, 20'h0,     1, 2, 1, 0, 20'h0,     0, 1, 0, 1)); // 12 drained
        vecs.push_back(v(0, 0, 20'h0,     0, 2, 1, 0, 20'h0,     0, 0, 0, 1));
        vecs.push_back(v(0, 0, 20'h0,     1, 2, 1, 0, 20'h0,     0, 0, 0, 1)); // 14 grant on empty
        vecs.push_back(v(0, 0, 20'h0,     0, 2, 1, 0, 20'h0,     0, 0, 0, 1)); // 15 still no credit
        vecs.push_back(v(0, 1, 20'h40001, 0, 2, 1, 1, 20'h40001, 0, 0, 1, 1));
        vecs.push_back(v(0, 1, 20'h40002, 0, 2, 1, 1, 20'h40001, 0, 0, 2, 1)); // 17 count=2
        vecs.push_back(v(0, 1, 20'h40010, 1, 2, 1, 1, 20'h40002, 0, 1, 2, 1)); // 18..23 simultaneous r/w, wrap
        vecs.push_back(v(0, 1, 20'h40011, 1, 2, 1, 1, 20'h40010, 0, 1, 2, 1));
        vecs.push_back(v(0, 1, 20'h40012, 1, 2, 1, 1, 20'h40011, 0, 1, 2, 1));
        vecs.push_back(v(0, 1, 20'h40013, 1, 2, 1, 1, 20'h40012, 0, 1, 2, 1));
        vecs.push_back(v(0, 1, 20'h40014, 1, 2, 1, 1, 20'h40013, 0, 1, 2, 1));
        vecs.push_back(v(0, 1, 20'h40015, 1, 2, 1, 1, 20'h40014, 0, 1, 2, 1));
        vecs.push_back(v(0, 0, 20'h0,     0, 2, 1, 1, 20'h40014, 0, 0, 2, 1)); // 24
        vecs.push_back(v(0, 0, 20'h0,     1, 2, 1, 1, 20'h40015, 0, 1, 1, 1));
        vecs.push_back(v(0, 0, 20'h0,     1, 2, 1, 0, 20'h0,     0, 1, 0, 1)); // 26
        vecs.push_back(v(0, 1, 20'h30000, 0, 2, 1, 1, 20'h30000, 0, 0, 1, 1)); // 27 dest 0/3, ids 2/1
        vecs.push_back(v(0, 0, 20'h0,     0, 0, 3, 1, 20'h30000, 1, 0, 1, 1)); // 28 ids 0/3
        vecs.push_back(v(0, 1, 20'h11111, 0, 2, 1, 1, 20'h30000, 0, 0, 2, 1));
        vecs.push_back(v(0, 1, 20'h22222, 0, 2, 1, 1, 20'h30000, 0, 0, 3, 1)); // 30 three buffered
        vecs.push_back(v(1, 1, 20'h33333, 1, 2, 1, 0, 20'h0,     0, 0, 0, 0)); // 31 reset mid-operation
        vecs.push_back(v(0, 1, 20'h12345, 0, 2, 1, 1, 20'h12345, 0, 0, 1, 0)); // 32 no stale credit
        vecs.push_back(v(0, 0, 20'h0,     1, 2, 1, 0, 20'h0,     0, 1, 0, 0));
        vecs.push_back(v(0, 0, 20'h0,     0, 2, 1, 0, 20'h0,     0, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_outs(vecs[i], i);
        end

        // head_local responds to ID changes within the cycle, no edge needed.
        @(negedge clk);
        drive(v(0, 1, 20'h30000, 0, 2, 1, 0, 20'h0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("hl_ids_2_1", 100, 32'(ifc.head_local), 32'd0);
        @(negedge clk);
        ifc.vi         = 1'b0;
        ifc.my_cluster = 2'd0;
        ifc.my_local   = 2'd3;
        #1;
        chk("hl_ids_0_3_same_cycle", 101, 32'(ifc.head_local), 32'd1);
        ifc.my_cluster = 2'd0;
        ifc.my_local   = 2'd2;
        #1;
        chk("hl_ids_0_2_same_cycle", 102, 32'(ifc.head_local), 32'd0);

        // Credit is registered: low during the grant cycle, high only after.
        ifc.grant = 1'b1;
        #1;
        chk("co_before_edge", 103, 32'(ifc.co), 32'd0);
        @(posedge clk);
        #1;
        chk("co_after_edge", 104, 32'(ifc.co), 32'd1);
        @(negedge clk);
        ifc.grant = 1'b0;
        @(posedge clk);
        #1;
        chk("co_single_pulse", 105, 32'(ifc.co), 32'd0);
        chk("count_empty", 106, 32'(ifc.count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
